// File: rtl/sum_pkg.sv
// sum_pkg: state encoding and default parameters shared by the sum sequencer.
package sum_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GOT_A = 2'd1,
        S_ADD   = 2'd2,
        S_SHOW  = 2'd3
    } state_t;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_BLINK_DIV = 25_000_000;
endpackage

// File: rtl/key_press.sv
// key_press: turns an active-low button into a one-cycle press pulse (no debounce).
module key_press (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic pressed
);
    logic k_r, k_rr;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_r  <= 1'b1;
            k_rr <= 1'b1;
        end else begin
            k_r  <= key;
            k_rr <= k_r;
        end
    end
    assign pressed = k_rr & ~k_r;
endmodule

// File: rtl/sum_sequencer.sv
// sum_sequencer: two-key operand entry, add and display of the sum on the LED banks,
// with a blinking carry LED while an overflowing sum is shown.
module sum_sequencer
    import sum_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int BLINK_DIV = DEF_BLINK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter_key,
    input  logic             clear_key,
    input  logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] red_leds,
    output logic [WIDTH-1:0] green_leds,
    output logic             carry_led,
    output logic [1:0]       state_leds
);
    localparam int CW = $clog2(BLINK_DIV);
    state_t state, next;
    logic enter_press, clear_press;
    logic load_a, load_b, do_add, clr, blink_run, blink;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH:0] sum;
    logic [CW-1:0] blink_cnt;
    key_press u_enter (.clk(clk), .reset(reset), .key(enter_key), .pressed(enter_press));
    key_press u_clear (.clk(clk), .reset(reset), .key(clear_key), .pressed(clear_press));
    always_comb begin
        next   = state;
        load_a = 1'b0;
        load_b = 1'b0;
        do_add = 1'b0;
        clr    = clear_press;
        if (clear_press) begin
            next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (enter_press) begin load_a = 1'b1; next = S_GOT_A; end
                S_GOT_A: if (enter_press) begin load_b = 1'b1; next = S_ADD; end
                S_ADD:   begin do_add = 1'b1; next = S_SHOW; end
                default: if (enter_press) begin load_a = 1'b1; next = S_GOT_A; end
            endcase
        end
    end
    // The counter only runs while the overflowing sum stays on display.
    assign blink_run = state == S_SHOW && sum[WIDTH] && !clear_press && !enter_press;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            sum       <= '0;
            red_leds  <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            state <= next;
            if (clr) begin
                op_a     <= '0;
                op_b     <= '0;
                sum      <= '0;
                red_leds <= '0;
            end else begin
                if (load_a) begin
                    op_a     <= switches;
                    red_leds <= switches;
                end
                if (load_b) begin
                    op_b     <= switches;
                    red_leds <= switches;
                end
                if (do_add)
                    sum <= {1'b0, op_a} + {1'b0, op_b};
            end
            if (blink_run) begin
                blink_cnt <= blink_cnt == CW'(BLINK_DIV - 1) ? '0 : blink_cnt + CW'(1);
                blink     <= blink_cnt == CW'(BLINK_DIV - 1) ? ~blink : blink;
            end else begin
                blink_cnt <= '0;
                blink     <= 1'b0;
            end
        end
    end
    assign green_leds = sum[WIDTH-1:0];
    assign carry_led  = blink;
    assign state_leds = state;
endmodule

// File: tb/tb_sum_sequencer.sv
// tb_sum_sequencer: directed scenarios plus randomized key sequences against a behavioural model.
module tb_sum_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enter_key = 1'b1;
    logic clear_key = 1'b1;
    logic [7:0] switches = 8'h00;
    logic [7:0] red_leds, green_leds;
    logic carry_led;
    logic [1:0] state_leds;
    logic [18:0] obs;
    int errors = 0;
    int checks = 0;

    sum_sequencer #(.WIDTH(8), .BLINK_DIV(4)) dut (
        .clk(clk), .reset(reset), .enter_key(enter_key), .clear_key(clear_key),
        .switches(switches), .red_leds(red_leds), .green_leds(green_leds),
        .carry_led(carry_led), .state_leds(state_leds)
    );

    always #5 clk = ~clk;
    assign obs = {state_leds, red_leds, green_leds, carry_led};

    task automatic press(input bit e, input bit c, input logic [7:0] sw);
        @(negedge clk);
        switches  = sw;
        enter_key = ~e;
        clear_key = ~c;
        repeat (3) @(negedge clk);
        enter_key = 1'b1;
        clear_key = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 19'h0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %h expected 0", i, obs);
            end
        end
    endtask

    task automatic test_basic_sum();
        press(1, 0, 8'h12);
        checks++;
        if (obs !== {2'd1, 8'h12, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL basic_got_a: got %h expected %h", obs, {2'd1, 8'h12, 8'h00, 1'b0});
        end
        @(negedge clk);
        switches  = 8'h34;
        enter_key = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== {2'd1, 8'h12, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL basic_pulse_cycle: got %h expected %h", obs, {2'd1, 8'h12, 8'h00, 1'b0});
        end
        @(negedge clk);
        checks++;
        if (obs !== {2'd2, 8'h34, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL basic_add_cycle: got %h expected %h", obs, {2'd2, 8'h34, 8'h00, 1'b0});
        end
        @(negedge clk);
        checks++;
        if (obs !== {2'd3, 8'h34, 8'h46, 1'b0}) begin
            errors++;
            $display("FAIL basic_show: got %h expected %h", obs, {2'd3, 8'h34, 8'h46, 1'b0});
        end
        enter_key = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (obs !== {2'd3, 8'h34, 8'h46, 1'b0}) begin
            errors++;
            $display("FAIL basic_hold: got %h expected %h", obs, {2'd3, 8'h34, 8'h46, 1'b0});
        end
    endtask

    task automatic test_carry_blink();
        logic [1:0] es;
        logic [7:0] er;
        logic ec;
        press(0, 1, 8'h00);
        press(1, 0, 8'hFF);
        @(negedge clk);
        switches  = 8'h01;
        enter_key = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 2) enter_key = 1'b1;
            es = k < 2 ? 2'd1 : (k == 2 ? 2'd2 : 2'd3);
            er = k < 2 ? 8'hFF : 8'h01;
            ec = k >= 3 ? (((k - 3) / 4) % 2 == 1) : 1'b0;
            checks++;
            if (obs !== {es, er, 8'h00, ec}) begin
                errors++;
                $display("FAIL carry_blink k=%0d: got %h expected %h", k, obs, {es, er, 8'h00, ec});
            end
        end
        @(negedge clk);
        clear_key = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 19'h0) begin
            errors++;
            $display("FAIL carry_clear: got %h expected 0", obs);
        end
        clear_key = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_enter_clear_same();
        press(1, 0, 8'h55);
        press(1, 1, 8'h66);
        checks++;
        if (obs !== 19'h0) begin
            errors++;
            $display("FAIL both_keys: got %h expected 0", obs);
        end
        press(1, 0, 8'h01);
        press(1, 0, 8'h02);
        checks++;
        if (obs !== {2'd3, 8'h02, 8'h03, 1'b0}) begin
            errors++;
            $display("FAIL both_keys_resume: got %h expected %h", obs, {2'd3, 8'h02, 8'h03, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        press(0, 1, 8'h00);
        press(1, 0, 8'h12);
        press(1, 0, 8'h34);
        press(1, 0, 8'h10);
        checks++;
        if (obs !== {2'd1, 8'h10, 8'h46, 1'b0}) begin
            errors++;
            $display("FAIL show_reenter: got %h expected %h", obs, {2'd1, 8'h10, 8'h46, 1'b0});
        end
        press(1, 0, 8'h05);
        checks++;
        if (obs !== {2'd3, 8'h05, 8'h15, 1'b0}) begin
            errors++;
            $display("FAIL show_second_sum: got %h expected %h", obs, {2'd3, 8'h05, 8'h15, 1'b0});
        end
    endtask

    task automatic test_async_reset();
        press(1, 0, 8'h77);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== 19'h0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", obs);
        end
        @(negedge clk);
        reset = 1'b0;
        press(1, 0, 8'h03);
        press(1, 0, 8'h04);
        checks++;
        if (obs !== {2'd3, 8'h04, 8'h07, 1'b0}) begin
            errors++;
            $display("FAIL reset_resume: got %h expected %h", obs, {2'd3, 8'h04, 8'h07, 1'b0});
        end
    endtask

    task automatic test_random();
        int m_phase = 0;
        logic [7:0] m_a = 0, m_red = 0;
        logic [8:0] m_sum = 0;
        logic [7:0] sw;
        bit c, e;
        press(0, 1, 8'h00);
        for (int i = 0; i < 40; i++) begin
            sw = 8'($urandom);
            c = $urandom_range(0, 4) == 0;
            e = !c || $urandom_range(0, 1) == 1;
            press(e, c, sw);
            if (c) begin
                m_phase = 0;
                m_a = 0;
                m_red = 0;
                m_sum = 0;
            end else if (m_phase == 1) begin
                m_sum = m_a + sw;
                m_red = sw;
                m_phase = 3;
            end else begin
                m_a = sw;
                m_red = sw;
                m_phase = 1;
            end
            checks++;
            if (obs[18:1] !== {2'(m_phase), m_red, m_sum[7:0]}) begin
                errors++;
                $display("FAIL random step %0d: got %h expected %h", i, obs[18:1], {2'(m_phase), m_red, m_sum[7:0]});
            end
            if (!(m_phase == 3 && m_sum[8])) begin
                checks++;
                if (carry_led !== 1'b0) begin
                    errors++;
                    $display("FAIL random_carry step %0d: got %b expected 0", i, carry_led);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_carry_blink();
        test_enter_clear_same();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
